// File: rtl/map_table_ckpt_pkg.sv
// Shared types and sizing for the rename map table and its branch checkpoint ring.
package map_table_ckpt_pkg;

    localparam int N_WAY  = 2;
    localparam int N_ARCH = 32;
    localparam int N_PHYS = 64;
    localparam int N_CDB  = 2;
    localparam int N_CKPT = 4;

    localparam int AB = $clog2(N_ARCH);
    localparam int PB = $clog2(N_PHYS);
    localparam int CB = $clog2(N_CKPT);

    typedef logic [AB-1:0] arch_reg_t;
    typedef logic [PB-1:0] phys_reg_t;
    typedef logic [CB-1:0] ckpt_tag_t;
    // One extra bit so a completely full ring is distinguishable from empty.
    typedef logic [CB:0]   ckpt_cnt_t;

    typedef struct packed {
        phys_reg_t pr;
        logic      rdy;
    } map_entry_t;

    localparam phys_reg_t X0_PR = phys_reg_t'(1);

endpackage

// File: rtl/map_table_ckpt_alloc.sv
// Checkpoint slot ring: allocates at tail, frees out of order, squashes younger on mispredict.
// State updates next cycle; br_tag/ckpt_full are straight from flops, ckpt_full blocks new branches.
module map_ckpt_alloc
    import map_table_ckpt_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      alloc_vld,
    input  logic      free_vld,
    input  ckpt_tag_t free_tag,
    input  logic      squash_vld,
    input  ckpt_tag_t squash_tag,
    output ckpt_tag_t br_tag,
    output logic      ckpt_full
);

    logic [N_CKPT-1:0] valid_q, valid_d;
    ckpt_tag_t         head_q, head_d;
    ckpt_tag_t         tail_q, tail_d;
    ckpt_cnt_t         count_q, count_d;
    ckpt_tag_t         rel;

    assign br_tag    = tail_q;
    assign ckpt_full = (count_q == ckpt_cnt_t'(N_CKPT));

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        rel     = ckpt_tag_t'(squash_tag - head_q);

        if (squash_vld) begin
            // Everything at or beyond the squashed slot's age position goes away.
            for (int i = 0; i < N_CKPT; i++) begin
                if (ckpt_tag_t'(ckpt_tag_t'(i) - head_q) >= rel) begin
                    valid_d[i] = 1'b0;
                end
            end
            tail_d  = squash_tag;
            count_d = {1'b0, rel};
        end else begin
            if (free_vld) begin
                valid_d[free_tag] = 1'b0;
            end
            if (alloc_vld && !ckpt_full) begin
                valid_d[tail_q] = 1'b1;
                tail_d  = tail_q + ckpt_tag_t'(1);
                count_d = count_q + ckpt_cnt_t'(1);
            end
        end

        // Reclaim resolved slots sitting at the oldest end of the ring.
        for (int i = 0; i < N_CKPT; i++) begin
            if (count_d != '0 && !valid_d[head_d]) begin
                head_d  = head_d + ckpt_tag_t'(1);
                count_d = count_d - ckpt_cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/map_table_ckpt.sv
// Rename map table with per-branch snapshots; lookups are combinational, updates land next cycle.
// Mispredict restores a snapshot in one cycle; upstream must hold branches while ckpt_full is set.
module map_table_ckpt
    import map_table_ckpt_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_WAY-1:0]           dis_valid,
    input  logic [N_WAY-1:0][AB-1:0]   dis_dest,
    input  logic [N_WAY-1:0][AB-1:0]   dis_src1,
    input  logic [N_WAY-1:0][AB-1:0]   dis_src2,
    input  logic [N_WAY-1:0][PB-1:0]   dis_newpr,
    input  logic [N_WAY-1:0]           dis_is_br,
    input  logic [N_CDB-1:0]           cdb_valid,
    input  logic [N_CDB-1:0][PB-1:0]   cdb_pr,
    input  logic                       rs_valid,
    input  logic [CB-1:0]              rs_tag,
    input  logic                       rs_mispred,
    output logic [N_WAY-1:0][PB-1:0]   src1_pr,
    output logic [N_WAY-1:0]           src1_rdy,
    output logic [N_WAY-1:0][PB-1:0]   src2_pr,
    output logic [N_WAY-1:0]           src2_rdy,
    output logic [N_WAY-1:0][PB-1:0]   told,
    output logic [CB-1:0]              br_tag,
    output logic                       ckpt_full
);

    map_entry_t map_q  [N_ARCH];
    map_entry_t map_d  [N_ARCH];
    map_entry_t ckpt_q [N_CKPT][N_ARCH];
    map_entry_t ckpt_d [N_CKPT][N_ARCH];

    logic mispred;
    logic br_req;
    logic dis_ok;
    logic alloc_vld;
    logic free_vld;

    assign mispred  = rs_valid & rs_mispred;
    assign free_vld = rs_valid & ~rs_mispred;
    assign br_req   = |(dis_valid & dis_is_br);
    assign dis_ok   = ~mispred & ~(br_req & ckpt_full);

    function automatic logic cdb_hit(input phys_reg_t pr);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < N_CDB; c++) begin
            hit = hit | (cdb_valid[c] & (cdb_pr[c] == pr));
        end
        return hit;
    endfunction

    // Later lanes overwrite earlier matches, so the youngest older producer wins.
    function automatic map_entry_t rename_src(input int lane, input arch_reg_t src);
        map_entry_t e;
        e     = map_q[src];
        e.rdy = e.rdy | cdb_hit(e.pr);
        for (int k = 0; k < N_WAY; k++) begin
            if (k < lane && dis_valid[k] && dis_dest[k] == src) begin
                e = '{pr: dis_newpr[k], rdy: 1'b0};
            end
        end
        if (src == '0) begin
            e = '{pr: X0_PR, rdy: 1'b1};
        end
        return e;
    endfunction

    function automatic phys_reg_t prev_map(input int lane);
        phys_reg_t p;
        p = map_q[dis_dest[lane]].pr;
        for (int k = 0; k < N_WAY; k++) begin
            if (k < lane && dis_valid[k] && dis_dest[k] == dis_dest[lane]) begin
                p = dis_newpr[k];
            end
        end
        if (!dis_valid[lane] || dis_dest[lane] == '0) begin
            p = '0;
        end
        return p;
    endfunction

    always_comb begin
        map_entry_t e1;
        map_entry_t e2;
        e1 = '0;
        e2 = '0;
        for (int n = 0; n < N_WAY; n++) begin
            e1          = rename_src(n, dis_src1[n]);
            e2          = rename_src(n, dis_src2[n]);
            src1_pr[n]  = e1.pr;
            src1_rdy[n] = e1.rdy;
            src2_pr[n]  = e2.pr;
            src2_rdy[n] = e2.rdy;
            told[n]     = prev_map(n);
        end
    end

    always_comb begin
        alloc_vld = 1'b0;
        for (int s = 0; s < N_CKPT; s++) begin
            for (int i = 0; i < N_ARCH; i++) begin
                ckpt_d[s][i]     = ckpt_q[s][i];
                ckpt_d[s][i].rdy = ckpt_q[s][i].rdy | cdb_hit(ckpt_q[s][i].pr);
            end
        end
        for (int i = 0; i < N_ARCH; i++) begin
            map_d[i]     = map_q[i];
            map_d[i].rdy = map_q[i].rdy | cdb_hit(map_q[i].pr);
        end

        if (mispred) begin
            // Snapshot already carries this cycle's completions via ckpt_d.
            for (int i = 0; i < N_ARCH; i++) begin
                map_d[i] = ckpt_d[rs_tag][i];
            end
        end else if (dis_ok) begin
            for (int n = 0; n < N_WAY; n++) begin
                if (dis_valid[n] && dis_dest[n] != '0) begin
                    map_d[dis_dest[n]] = '{pr: dis_newpr[n], rdy: 1'b0};
                end
                if (dis_valid[n] && dis_is_br[n]) begin
                    for (int i = 0; i < N_ARCH; i++) begin
                        ckpt_d[br_tag][i] = map_d[i];
                    end
                    alloc_vld = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_ARCH; i++) begin
                map_q[i] <= '{pr: phys_reg_t'(i + 1), rdy: 1'b1};
            end
        end else begin
            map_q <= map_d;
        end
    end

    // Snapshot contents only matter while their slot is valid, so no reset.
    always_ff @(posedge clock) begin
        ckpt_q <= ckpt_d;
    end

    map_ckpt_alloc u_alloc (
        .clock      (clock),
        .reset      (reset),
        .alloc_vld  (alloc_vld),
        .free_vld   (free_vld),
        .free_tag   (rs_tag),
        .squash_vld (mispred),
        .squash_tag (rs_tag),
        .br_tag     (br_tag),
        .ckpt_full  (ckpt_full)
    );

    a_no_br_when_full: assert property (@(posedge clock) disable iff (reset)
        !(br_req && ckpt_full && !mispred));

endmodule

// File: tb/tb_map_table_ckpt.sv
// Scoreboard bench for map_table_ckpt: directed scenarios then random traffic against a reference model.
module tb_map_table_ckpt;
    import map_table_ckpt_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [N_WAY-1:0]         dis_valid, dis_is_br;
    logic [N_WAY-1:0][AB-1:0] dis_dest, dis_src1, dis_src2;
    logic [N_WAY-1:0][PB-1:0] dis_newpr;
    logic [N_CDB-1:0]         cdb_valid;
    logic [N_CDB-1:0][PB-1:0] cdb_pr;
    logic                     rs_valid, rs_mispred;
    logic [CB-1:0]            rs_tag;
    logic [N_WAY-1:0][PB-1:0] src1_pr, src2_pr, told;
    logic [N_WAY-1:0]         src1_rdy, src2_rdy;
    logic [CB-1:0]            br_tag;
    logic                     ckpt_full;

    map_table_ckpt dut (
        .clock(clock), .reset(reset),
        .dis_valid(dis_valid), .dis_dest(dis_dest), .dis_src1(dis_src1), .dis_src2(dis_src2),
        .dis_newpr(dis_newpr), .dis_is_br(dis_is_br),
        .cdb_valid(cdb_valid), .cdb_pr(cdb_pr),
        .rs_valid(rs_valid), .rs_tag(rs_tag), .rs_mispred(rs_mispred),
        .src1_pr(src1_pr), .src1_rdy(src1_rdy), .src2_pr(src2_pr), .src2_rdy(src2_rdy),
        .told(told), .br_tag(br_tag), .ckpt_full(ckpt_full)
    );

    typedef struct packed {
        logic [N_WAY-1:0][PB-1:0] s1pr;
        logic [N_WAY-1:0][PB-1:0] s2pr;
        logic [N_WAY-1:0][PB-1:0] told;
        logic [N_WAY-1:0]         s1r;
        logic [N_WAY-1:0]         s2r;
        logic [CB-1:0]            brtag;
        logic                     full;
    } exp_t;

    exp_t expq[$];
    int   n_err = 0;
    int   n_chk = 0;

    // Reference model: architectural map, per-tag snapshots, and an age-ordered list of live tags.
    int mpr  [N_ARCH];
    bit mrdy [N_ARCH];
    int spr  [N_CKPT][N_ARCH];
    bit srdy [N_CKPT][N_ARCH];
    int ring_tag[$];
    bit ring_done[$];
    int tail_m;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit m_cdb(input int pr);
        for (int c = 0; c < N_CDB; c++)
            if (cdb_valid[c] && int'(cdb_pr[c]) == pr) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_src(input int n, input int src, output int pr, output bit rdy);
        int found = -1;
        for (int k = 0; k < n; k++)
            if (dis_valid[k] && int'(dis_dest[k]) == src) found = k;
        if (src == 0) begin
            pr = 1; rdy = 1'b1;
        end else if (found >= 0) begin
            pr = int'(dis_newpr[found]); rdy = 1'b0;
        end else begin
            pr = mpr[src]; rdy = mrdy[src] || m_cdb(mpr[src]);
        end
    endfunction

    function automatic int m_told(input int n);
        int d = int'(dis_dest[n]);
        int r;
        if (!dis_valid[n] || d == 0) return 0;
        r = mpr[d];
        for (int k = 0; k < n; k++)
            if (dis_valid[k] && int'(dis_dest[k]) == d) r = int'(dis_newpr[k]);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_ARCH; i++) begin
            mpr[i] = i + 1; mrdy[i] = 1'b1;
        end
        ring_tag.delete(); ring_done.delete(); tail_m = 0;
    endtask

    task automatic sb_push();
        exp_t e;
        int   pr;
        bit   r;
        for (int n = 0; n < N_WAY; n++) begin
            m_src(n, int'(dis_src1[n]), pr, r); e.s1pr[n] = phys_reg_t'(pr); e.s1r[n] = r;
            m_src(n, int'(dis_src2[n]), pr, r); e.s2pr[n] = phys_reg_t'(pr); e.s2r[n] = r;
            e.told[n] = phys_reg_t'(m_told(n));
        end
        e.brtag = ckpt_tag_t'(tail_m);
        e.full  = (ring_tag.size() == N_CKPT);
        expq.push_back(e);
    endtask

    task automatic model_next();
        int idx;
        for (int i = 0; i < N_ARCH; i++) if (m_cdb(mpr[i])) mrdy[i] = 1'b1;
        for (int t = 0; t < N_CKPT; t++)
            for (int i = 0; i < N_ARCH; i++) if (m_cdb(spr[t][i])) srdy[t][i] = 1'b1;
        if (rs_valid && rs_mispred) begin
            for (int i = 0; i < N_ARCH; i++) begin
                mpr[i] = spr[rs_tag][i]; mrdy[i] = srdy[rs_tag][i];
            end
            idx = ring_tag.size();
            for (int j = 0; j < ring_tag.size(); j++) if (ring_tag[j] == int'(rs_tag)) idx = j;
            while (ring_tag.size() > idx) begin
                void'(ring_tag.pop_back()); void'(ring_done.pop_back());
            end
            tail_m = int'(rs_tag);
        end else begin
            if (rs_valid)
                for (int j = 0; j < ring_tag.size(); j++) if (ring_tag[j] == int'(rs_tag)) ring_done[j] = 1'b1;
            while (ring_tag.size() > 0 && ring_done[0]) begin
                void'(ring_tag.pop_front()); void'(ring_done.pop_front());
            end
            for (int n = 0; n < N_WAY; n++) begin
                if (dis_valid[n] && dis_dest[n] != 0) begin
                    mpr[dis_dest[n]] = int'(dis_newpr[n]); mrdy[dis_dest[n]] = 1'b0;
                end
                if (dis_valid[n] && dis_is_br[n]) begin
                    for (int i = 0; i < N_ARCH; i++) begin
                        spr[tail_m][i] = mpr[i]; srdy[tail_m][i] = mrdy[i];
                    end
                    ring_tag.push_back(tail_m); ring_done.push_back(1'b0);
                    tail_m = (tail_m + 1) % N_CKPT;
                end
            end
        end
    endtask

    task automatic clear_in();
        dis_valid = '0; dis_is_br = '0; dis_dest = '0; dis_src1 = '0; dis_src2 = '0;
        dis_newpr = '0; cdb_valid = '0; cdb_pr = '0;
        rs_valid = 1'b0; rs_tag = '0; rs_mispred = 1'b0;
    endtask

    task automatic go();
        sb_push();
        model_next();
        #3;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        clear_in();
    endtask

    function automatic int rand_reg();
        return ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, N_ARCH - 1));
    endfunction

    task automatic rand_in();
        int cand[$];
        for (int n = 0; n < N_WAY; n++) begin
            dis_valid[n] = ($urandom_range(0, 3) != 0);
            dis_dest[n]  = arch_reg_t'(rand_reg());
            dis_src1[n]  = arch_reg_t'(rand_reg());
            dis_src2[n]  = arch_reg_t'(rand_reg());
            dis_newpr[n] = phys_reg_t'($urandom_range(2, N_PHYS - 1));
        end
        if (ring_tag.size() < N_CKPT && $urandom_range(0, 3) == 0)
            dis_is_br[$urandom_range(0, N_WAY - 1)] = 1'b1;
        for (int c = 0; c < N_CDB; c++) begin
            cdb_valid[c] = ($urandom_range(0, 1) != 0);
            cdb_pr[c]    = phys_reg_t'(mpr[$urandom_range(0, N_ARCH - 1)]);
        end
        for (int j = 0; j < ring_tag.size(); j++) if (!ring_done[j]) cand.push_back(ring_tag[j]);
        if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
            rs_valid   = 1'b1;
            rs_tag     = ckpt_tag_t'(cand[$urandom_range(0, cand.size() - 1)]);
            rs_mispred = ($urandom_range(0, 2) == 0);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("sb_src1_pr", src1_pr, e.s1pr);
                chk("sb_src1_rdy", src1_rdy, e.s1r);
                chk("sb_src2_pr", src2_pr, e.s2pr);
                chk("sb_src2_rdy", src2_rdy, e.s2r);
                chk("sb_told", told, e.told);
                chk("sb_br_tag", br_tag, e.brtag);
                chk("sb_ckpt_full", ckpt_full, e.full);
            end
        end
    end

    initial begin
        reset = 1'b1;
        clear_in();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();

        // Reset state and x0 handling.
        dis_valid[0] = 1'b1; dis_src1[0] = 5; dis_src2[0] = 0; dis_dest[0] = 5; dis_newpr[0] = 33;
        go();
        chk("t1_src1_pr", src1_pr[0], 6);
        chk("t1_src1_rdy", src1_rdy[0], 1);
        chk("t1_src2_x0", src2_pr[0], 1);
        chk("t1_told", told[0], 6);
        chk("t1_full", ckpt_full, 0);
        tick();

        // Intra-group forwarding.
        dis_valid = 2'b11; dis_dest[0] = 3; dis_newpr[0] = 40;
        dis_src1[1] = 3; dis_dest[1] = 3; dis_newpr[1] = 41;
        go();
        chk("t2_fwd_pr", src1_pr[1], 40);
        chk("t2_fwd_rdy", src1_rdy[1], 0);
        chk("t2_told", told[1], 40);
        tick();
        dis_src1[0] = 3;
        go();
        chk("t2_next_pr", src1_pr[0], 41);
        chk("t2_next_rdy", src1_rdy[0], 0);
        tick();

        // CDB bypass on lookup and map wakeup.
        dis_valid[0] = 1'b1; dis_dest[0] = 7; dis_newpr[0] = 40;
        go(); tick();
        dis_src1[0] = 7; cdb_valid[0] = 1'b1; cdb_pr[0] = 40;
        go();
        chk("t3_bypass_rdy", src1_rdy[0], 1);
        tick();
        dis_src1[0] = 7;
        go();
        chk("t3_map_rdy", src1_rdy[0], 1);
        tick();

        // Branch then mispredict restores pre-lane1 map.
        dis_valid = 2'b11; dis_is_br[0] = 1'b1; dis_dest[1] = 2; dis_newpr[1] = 50;
        go();
        chk("t4_br_tag", br_tag, 0);
        tick();
        rs_valid = 1'b1; rs_tag = 0; rs_mispred = 1'b1;
        go(); tick();
        dis_src1[0] = 2;
        go();
        chk("t4_restored_pr", src1_pr[0], 3);
        chk("t4_tail", br_tag, 0);
        chk("t4_full", ckpt_full, 0);
        tick();

        // Fill the ring, then out-of-order resolves.
        for (int b = 0; b < N_CKPT; b++) begin
            dis_valid[0] = 1'b1; dis_is_br[0] = 1'b1;
            go();
            chk("t5_alloc_tag", br_tag, b);
            tick();
        end
        go();
        chk("t5_full", ckpt_full, 1);
        tick();
        rs_valid = 1'b1; rs_tag = 2;
        go(); tick();
        go();
        chk("t5_full_after_tag2", ckpt_full, 1);
        tick();
        rs_valid = 1'b1; rs_tag = 0;
        go(); tick();
        go();
        chk("t5_full_after_tag0", ckpt_full, 0);
        tick();

        // Mispredict with simultaneous dispatch and CDB.
        rs_valid = 1'b1; rs_tag = 1; rs_mispred = 1'b1;
        dis_valid = 2'b11; dis_is_br[0] = 1'b1; dis_dest[1] = 9; dis_newpr[1] = 60;
        cdb_valid[0] = 1'b1; cdb_pr[0] = 33;
        go(); tick();
        dis_src1[0] = 5; dis_src2[0] = 9;
        go();
        chk("t6_restore_pr", src1_pr[0], 33);
        chk("t6_cdb_merged", src1_rdy[0], 1);
        chk("t6_drop_write", src2_pr[0], 10);
        chk("t6_no_alloc", br_tag, 1);
        tick();

        for (int i = 0; i < 3000; i++) begin
            rand_in();
            go();
            tick();
        end

        @(negedge clock);
        #1;
        chk("sb_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
